// File: rtl/clock_div_prog.sv
// clock_div_prog: runtime-programmable clock divider.
// Produces a registered near-50%-duty divided clock (clk_out) and a one-cycle
// period strobe (tick) from clk_in. Start/stop is glitch-free: a stop request
// lets the current period finish before going idle. Divisor reloads take
// effect on period boundaries, or one cycle after capture when idle.
//
// Optional feature macro: CLOCK_DIV_SYNC_EN
//   defined   -> adds input 'sync' which forces a new period while running.
//   undefined -> no sync port; periods are aligned only by the en start.
module clock_div_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
`ifdef CLOCK_DIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             div_ack,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [WIDTH-1:0] cur_div
);

  localparam logic [WIDTH-1:0] MIN_DIV   = WIDTH'(2);
  localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] cur_div_q,  cur_div_d;
  logic [WIDTH-1:0] pend_q,     pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_out_q,  clk_out_d;
  logic             tick_q,     tick_d;
  logic             div_ack_q,  div_ack_d;
  logic             running_q,  running_d;

  // Combinational helpers
  logic [WIDTH-1:0] div_clamped;
  logic [WIDTH-1:0] n_next;
  logic [WIDTH-1:0] high_len;
  logic             wrap;
  logic             sync_hit;
  logic             apply;
  logic             start;

  // Divisors below 2 cannot produce a clock, so they are promoted to 2.
  assign div_clamped = (div_val < MIN_DIV) ? MIN_DIV : div_val;

  // Boundary edge: the counter sits on the last cycle of the current period.
  assign wrap = (cnt_q == (cur_div_q - 1'b1));

`ifdef CLOCK_DIV_SYNC_EN
  // A sync request only matters while periods are being generated.
  assign sync_hit = sync && (state_q != ST_IDLE);
`else
  assign sync_hit = 1'b0;
`endif

  // High phase length is ceil(N/2); computed without needing an extra bit.
  assign high_len = {1'b0, n_next[WIDTH-1:1]} + {{(WIDTH-1){1'b0}}, n_next[0]};

  // Next-state, counter, divisor-apply and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    clk_out_d  = 1'b0;
    tick_d     = 1'b0;
    div_ack_d  = 1'b0;
    running_d  = 1'b0;
    apply      = 1'b0;
    start      = 1'b0;
    n_next     = cur_div_q;

    case (state_q)
      ST_IDLE: begin
        // No period is in flight, so a pending divisor can land immediately.
        apply = pend_vld_q;
        if (en) begin
          state_d = ST_RUN;
          start   = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (wrap || sync_hit) begin
          apply = pend_vld_q;
          start = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        state_d = en ? ST_RUN : ST_DRAIN;
        // A draining divider stops exactly at its boundary; a sync on the
        // same edge wins and the drain then completes on the new period.
        if ((state_q == ST_DRAIN) && !en && wrap && !sync_hit) begin
          state_d = ST_IDLE;
          start   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (apply) begin
      cur_div_d  = pend_q;
      n_next     = pend_q;
      div_ack_d  = 1'b1;
      pend_vld_d = 1'b0;
    end

    if (start) begin
      cnt_d = '0;
    end

    if (state_d == ST_IDLE) begin
      cnt_d = '0;
    end else begin
      running_d = 1'b1;
      clk_out_d = (cnt_d < high_len);
      tick_d    = start;
    end

    // A new capture always overrides; if it coincides with an apply, the
    // old pending value lands now and the new one waits for the next chance.
    if (div_load) begin
      pend_d     = div_clamped;
      pend_vld_d = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cur_div_q  <= RESET_DIV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      div_ack_q  <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      div_ack_q  <= div_ack_d;
      running_q  <= running_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign div_ack = div_ack_q;
  assign running = running_q;
  assign cur_div = cur_div_q;

endmodule

// File: tb/tb_clock_div_prog.sv
// Directed self-checking bench for clock_div_prog (WIDTH=16, DEFAULT_DIV=4).
// Sync scenarios are exercised when CLOCK_DIV_SYNC_EN is defined.
module tb_clock_div_prog;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] div_val;
  logic        div_load;
`ifdef CLOCK_DIV_SYNC_EN
  logic        sync;
`endif
  logic        div_ack;
  logic        clk_out;
  logic        tick;
  logic        running;
  logic [15:0] cur_div;

  int total = 0;
  int bad   = 0;

  clock_div_prog #(.WIDTH(16), .DEFAULT_DIV(4)) dut (
    .clk_in   (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
`ifdef CLOCK_DIV_SYNC_EN
    .sync     (sync),
`endif
    .div_ack  (div_ack),
    .clk_out  (clk_out),
    .tick     (tick),
    .running  (running),
    .cur_div  (cur_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stop and wait for IDLE, bounded.
  task automatic go_idle(input string name);
    int n;
    en = 1'b0;
    n  = 0;
    while (running === 1'b1 && n < 100) begin
      step();
      n++;
    end
    total++;
    if (running !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: running=%b required 0 after %0d cycles", name, running, n);
    end
  endtask

  // Capture a divisor in IDLE and check the ack/cur_div one edge later.
  task automatic load_idle(input string name, input logic [15:0] v, input logic [15:0] exp_div);
    div_val = v; div_load = 1'b1;
    step();
    div_load = 1'b0;
    total++;
    if (div_ack !== 1'b0) begin
      bad++; $display("FAIL %s_early_ack: div_ack=%b required 0", name, div_ack);
    end
    step();
    total++;
    if ({div_ack, cur_div} !== {1'b1, exp_div}) begin
      bad++; $display("FAIL %s_ack: div_ack=%b cur_div=%0d required 1/%0d", name, div_ack, cur_div, exp_div);
    end
    step();
    total++;
    if (div_ack !== 1'b0) begin
      bad++; $display("FAIL %s_ack_len: div_ack=%b required 0", name, div_ack);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; div_val = '0; div_load = 1'b0;
`ifdef CLOCK_DIV_SYNC_EN
    sync = 1'b0;
`endif
    step(); step();
    total++;
    if ({clk_out, tick, div_ack, running} !== 4'b0000) begin
      bad++; $display("FAIL reset_outs: clk_out/tick/ack/running=%b%b%b%b required 0000", clk_out, tick, div_ack, running);
    end
    total++;
    if (cur_div !== 16'd4) begin
      bad++; $display("FAIL reset_div: cur_div=%0d required 4", cur_div);
    end
    rst_n = 1'b1;
    step();
    total++;
    if ({clk_out, tick, running} !== 3'b000) begin
      bad++; $display("FAIL reset_idle: clk_out/tick/running=%b%b%b required 000", clk_out, tick, running);
    end
    $display("test_reset done");
  endtask

  task automatic test_default_div();
    logic ec, et;
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      ec = ((i % 4) < 2);
      et = ((i % 4) == 0);
      total++;
      if ({clk_out, tick, running} !== {ec, et, 1'b1}) begin
        bad++; $display("FAIL div4_cyc%0d: clk/tick/run=%b%b%b required %b%b1", i, clk_out, tick, running, ec, et);
      end
    end
    go_idle("div4");
    $display("test_default_div done");
  endtask

  task automatic test_odd_div();
    logic ec, et;
    load_idle("odd", 16'd5, 16'd5);
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      ec = ((i % 5) < 3);
      et = ((i % 5) == 0);
      total++;
      if ({clk_out, tick, div_ack} !== {ec, et, 1'b0}) begin
        bad++; $display("FAIL odd5_cyc%0d: clk/tick/ack=%b%b%b required %b%b0", i, clk_out, tick, div_ack, ec, et);
      end
    end
    go_idle("odd");
    $display("test_odd_div done");
  endtask

  task automatic test_midrun_reload();
    logic ec, et, ea;
    load_idle("reload4", 16'd4, 16'd4);
    en = 1'b1;
    step();            // counter 0
    step();            // counter 1
    div_val = 16'd6; div_load = 1'b1;
    step();            // counter 2, load captured
    div_load = 1'b0;
    step();            // counter 3
    total++;
    if ({cur_div, div_ack, clk_out} !== {16'd4, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reload_old_period: cur_div=%0d ack=%b clk=%b required 4/0/0", cur_div, div_ack, clk_out);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      ec = ((i % 6) < 3);
      et = ((i % 6) == 0);
      ea = (i == 0);
      total++;
      if ({clk_out, tick, div_ack, cur_div} !== {ec, et, ea, 16'd6}) begin
        bad++; $display("FAIL reload6_cyc%0d: clk/tick/ack=%b%b%b cur_div=%0d required %b%b%b/6", i, clk_out, tick, div_ack, cur_div, ec, et, ea);
      end
    end
    go_idle("reload");
    $display("test_midrun_reload done");
  endtask

  task automatic test_clamp();
    load_idle("clamp0", 16'd0, 16'd2);
    load_idle("clamp1", 16'd1, 16'd2);
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if ({clk_out, tick} !== {(i % 2) == 0, (i % 2) == 0}) begin
        bad++; $display("FAIL clamp_cyc%0d: clk/tick=%b%b required %b%b", i, clk_out, tick, (i % 2) == 0, (i % 2) == 0);
      end
    end
    // Counter is at 1 (last cycle), so the next edge is a boundary edge.
    div_val = 16'd3; div_load = 1'b1;
    step();
    div_load = 1'b0;
    total++;
    if ({tick, div_ack, cur_div} !== {1'b1, 1'b0, 16'd2}) begin
      bad++; $display("FAIL boundary_load_now: tick=%b ack=%b cur_div=%0d required 1/0/2", tick, div_ack, cur_div);
    end
    step();
    total++;
    if ({tick, div_ack, clk_out} !== 3'b000) begin
      bad++; $display("FAIL boundary_load_mid: tick/ack/clk=%b%b%b required 000", tick, div_ack, clk_out);
    end
    step();
    total++;
    if ({tick, div_ack, clk_out, cur_div} !== {3'b111, 16'd3}) begin
      bad++; $display("FAIL boundary_load_next: tick/ack/clk=%b%b%b cur_div=%0d required 111/3", tick, div_ack, clk_out, cur_div);
    end
    step();
    total++;
    if ({clk_out, tick} !== 2'b10) begin
      bad++; $display("FAIL div3_cyc1: clk/tick=%b%b required 10", clk_out, tick);
    end
    step();
    total++;
    if ({clk_out, tick} !== 2'b00) begin
      bad++; $display("FAIL div3_cyc2: clk/tick=%b%b required 00", clk_out, tick);
    end
    go_idle("clamp");
    $display("test_clamp done");
  endtask

  task automatic test_stop_restart();
    logic et;
    load_idle("stop6", 16'd6, 16'd6);
    en = 1'b1;
    step();            // counter 0
    en = 1'b0;
    for (int j = 1; j < 6; j++) begin
      step();
      total++;
      if ({running, clk_out} !== {1'b1, j < 3}) begin
        bad++; $display("FAIL drain_cyc%0d: run/clk=%b%b required 1%b", j, running, clk_out, j < 3);
      end
    end
    step();
    total++;
    if ({running, clk_out, tick} !== 3'b000) begin
      bad++; $display("FAIL drain_end: run/clk/tick=%b%b%b required 000", running, clk_out, tick);
    end
    // Second run: drop en briefly and reassert inside the drain.
    en = 1'b1;
    step();
    total++;
    if ({tick, clk_out} !== 2'b11) begin
      bad++; $display("FAIL restart_tick: tick/clk=%b%b required 11", tick, clk_out);
    end
    en = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 2) en = 1'b1;
      et = ((k % 6) == 0);
      total++;
      if ({tick, running} !== {et, 1'b1}) begin
        bad++; $display("FAIL rearm_cyc%0d: tick/run=%b%b required %b1", k, tick, running, et);
      end
    end
    go_idle("stop");
    $display("test_stop_restart done");
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    step();            // counter 0 of N=6
    step();            // counter 1
    div_val = 16'd9; div_load = 1'b1;
    step();            // counter 2, still high, load pending
    div_load = 1'b0;
    total++;
    if (clk_out !== 1'b1) begin
      bad++; $display("FAIL rstmid_high: clk_out=%b required 1", clk_out);
    end
    rst_n = 1'b0;
    step();
    total++;
    if ({clk_out, tick, div_ack, running, cur_div} !== {4'b0000, 16'd4}) begin
      bad++; $display("FAIL rstmid_outs: clk/tick/ack/run=%b%b%b%b cur_div=%0d required 0000/4", clk_out, tick, div_ack, running, cur_div);
    end
    rst_n = 1'b1; en = 1'b0;
    step();
    step();
    total++;
    if ({div_ack, cur_div} !== {1'b0, 16'd4}) begin
      bad++; $display("FAIL rstmid_discard: ack=%b cur_div=%0d required 0/4", div_ack, cur_div);
    end
    $display("test_reset_mid done");
  endtask

`ifdef CLOCK_DIV_SYNC_EN
  task automatic test_sync();
    load_idle("sync8", 16'd8, 16'd8);
    en = 1'b1;
    step(); step(); step();   // counter 2
    sync = 1'b1;
    step();
    sync = 1'b0;
    total++;
    if ({tick, clk_out} !== 2'b11) begin
      bad++; $display("FAIL sync_restart: tick/clk=%b%b required 11", tick, clk_out);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      total++;
      if ({tick, clk_out} !== {k == 8, (k % 8) < 4}) begin
        bad++; $display("FAIL sync_cyc%0d: tick/clk=%b%b required %b%b", k, tick, clk_out, k == 8, (k % 8) < 4);
      end
    end
    // Sync together with stop: new period starts, then drains fully.
    en = 1'b0; sync = 1'b1;
    step();
    sync = 1'b0;
    total++;
    if ({tick, running} !== 2'b11) begin
      bad++; $display("FAIL sync_stop_start: tick/run=%b%b required 11", tick, running);
    end
    for (int j = 1; j < 8; j++) begin
      step();
      total++;
      if (running !== 1'b1) begin
        bad++; $display("FAIL sync_stop_cyc%0d: run=%b required 1", j, running);
      end
    end
    step();
    total++;
    if (running !== 1'b0) begin
      bad++; $display("FAIL sync_stop_end: run=%b required 0", running);
    end
    sync = 1'b1;
    step();
    sync = 1'b0;
    total++;
    if ({running, tick, clk_out} !== 3'b000) begin
      bad++; $display("FAIL sync_idle: run/tick/clk=%b%b%b required 000", running, tick, clk_out);
    end
    $display("test_sync done");
  endtask
`endif

  initial begin
    test_reset();
    test_default_div();
    test_odd_div();
    test_midrun_reload();
    test_clamp();
    test_stop_restart();
    test_reset_mid();
`ifdef CLOCK_DIV_SYNC_EN
    test_sync();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
